// File: rtl/pipeline_hazard_ctrl_pkg.sv
// Shared constants for the pipeline hazard controller: FSM encoding,
// register-file geometry and the syscall code that does not halt.
package pipeline_hazard_ctrl_pkg;

  localparam int unsigned REG_BITS   = 5;
  localparam int unsigned STATE_BITS = 2;

  localparam logic [STATE_BITS-1:0] ST_RUN     = 2'd0;
  localparam logic [STATE_BITS-1:0] ST_HALT    = 2'd1;
  localparam logic [STATE_BITS-1:0] ST_RELEASE = 2'd2;

  localparam logic [REG_BITS-1:0] REG_ZERO = 5'd0;

  localparam int unsigned DEFAULT_RUN_CODE = 34;

  // A source matches a stage only if that stage writes and the register is not r0.
  function automatic logic reg_hit(input logic [REG_BITS-1:0] src,
                                   input logic [REG_BITS-1:0] dst,
                                   input logic                we);
    return we && (dst == src) && (dst != REG_ZERO);
  endfunction

endpackage

// File: rtl/hazard_raw_detect.sv
// Combinational RAW detector: ID source registers against the EX, MEM and WB
// destinations. WB counts because the register file has no write-through.
module hazard_raw_detect
  import pipeline_hazard_ctrl_pkg::*;
(
  input  logic [REG_BITS-1:0] id_rs,
  input  logic [REG_BITS-1:0] id_rt,
  input  logic                id_use_rs,
  input  logic                id_use_rt,
  input  logic [REG_BITS-1:0] ex_write,
  input  logic                ex_regwrite,
  input  logic [REG_BITS-1:0] mem_write,
  input  logic                mem_regwrite,
  input  logic [REG_BITS-1:0] wb_write,
  input  logic                wb_regwrite,
  output logic                raw_c
);

  logic rs_hit;
  logic rt_hit;

  always_comb begin
    rs_hit = reg_hit(id_rs, ex_write, ex_regwrite)
           | reg_hit(id_rs, mem_write, mem_regwrite)
           | reg_hit(id_rs, wb_write, wb_regwrite);
    rt_hit = reg_hit(id_rt, ex_write, ex_regwrite)
           | reg_hit(id_rt, mem_write, mem_regwrite)
           | reg_hit(id_rt, wb_write, wb_regwrite);
  end

  assign raw_c = (id_use_rs & rs_hit) | (id_use_rt & rt_hit);

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Pipeline stall/flush control with syscall halt FSM and statistics counters.
// Control outputs are combinational from the FSM state and the current inputs.
module pipeline_hazard_ctrl
  import pipeline_hazard_ctrl_pkg::*;
#(
  parameter int unsigned DATA_BITS = 32,
  parameter int unsigned CNT_BITS  = 32,
  parameter int unsigned RUN_CODE  = DEFAULT_RUN_CODE
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [REG_BITS-1:0]  id_rs,
  input  logic [REG_BITS-1:0]  id_rt,
  input  logic                 id_use_rs,
  input  logic                 id_use_rt,
  input  logic [REG_BITS-1:0]  ex_write,
  input  logic                 ex_regwrite,
  input  logic [REG_BITS-1:0]  mem_write,
  input  logic                 mem_regwrite,
  input  logic [REG_BITS-1:0]  wb_write,
  input  logic                 wb_regwrite,
  input  logic                 ex_redirect,
  input  logic                 ex_syscall,
  input  logic [DATA_BITS-1:0] ex_v0,
  input  logic                 go,
  output logic                 pc_en,
  output logic                 if_id_en,
  output logic                 if_id_zero,
  output logic                 id_ex_en,
  output logic                 id_ex_zero,
  output logic                 ex_mem_en,
  output logic                 mem_wb_en,
  output logic                 halted,
  output logic [CNT_BITS-1:0]  stall_cnt,
  output logic [CNT_BITS-1:0]  flush_cnt
);

  logic [STATE_BITS-1:0] state;
  logic [STATE_BITS-1:0] state_nx;
  logic                  go_q;
  logic                  go_rise;
  logic                  raw;
  logic                  stall_inc;
  logic                  flush_inc;
  logic                  sys_halt;

  hazard_raw_detect u_raw (
    .id_rs        (id_rs),
    .id_rt        (id_rt),
    .id_use_rs    (id_use_rs),
    .id_use_rt    (id_use_rt),
    .ex_write     (ex_write),
    .ex_regwrite  (ex_regwrite),
    .mem_write    (mem_write),
    .mem_regwrite (mem_regwrite),
    .wb_write     (wb_write),
    .wb_regwrite  (wb_regwrite),
    .raw_c        (raw)
  );

  assign go_rise  = go & ~go_q;
  assign sys_halt = ex_syscall && (ex_v0 != DATA_BITS'(RUN_CODE));

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_RUN;
      go_q      <= 1'b0;
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      state <= state_nx;
      go_q  <= go;
      if (stall_inc) stall_cnt <= stall_cnt + CNT_BITS'(1);
      if (flush_inc) flush_cnt <= flush_cnt + CNT_BITS'(1);
    end
  end

  // Next state and controls; RELEASE shares RUN's rules minus the syscall check.
  always_comb begin
    state_nx   = state;
    pc_en      = 1'b1;
    if_id_en   = 1'b1;
    if_id_zero = 1'b0;
    id_ex_en   = 1'b1;
    id_ex_zero = 1'b0;
    ex_mem_en  = 1'b1;
    mem_wb_en  = 1'b1;
    halted     = 1'b0;
    stall_inc  = 1'b0;
    flush_inc  = 1'b0;
    if (!rst) begin
      case (state)
        ST_HALT: begin
          pc_en     = 1'b0;
          if_id_en  = 1'b0;
          id_ex_en  = 1'b0;
          ex_mem_en = 1'b0;
          mem_wb_en = 1'b0;
          halted    = 1'b1;
          if (go_rise) state_nx = ST_RELEASE;
        end
        ST_RUN, ST_RELEASE: begin
          if (state == ST_RELEASE) state_nx = ST_RUN;
          if ((state == ST_RUN) && sys_halt) begin
            pc_en     = 1'b0;
            if_id_en  = 1'b0;
            id_ex_en  = 1'b0;
            ex_mem_en = 1'b0;
            mem_wb_en = 1'b0;
            state_nx  = ST_HALT;
          end else if (ex_redirect) begin
            if_id_zero = 1'b1;
            id_ex_zero = 1'b1;
            flush_inc  = 1'b1;
          end else if (raw) begin
            pc_en      = 1'b0;
            if_id_en   = 1'b0;
            id_ex_zero = 1'b1;
            stall_inc  = 1'b1;
          end
        end
        default: state_nx = ST_RUN;
      endcase
    end
  end

endmodule
